// File: rtl/nand_page_program.sv
// nand_page_program: runs one ONFI-style page program on the flash pins.
// The sequence is 0x80, five address cycles, N data bytes, 0x10, a wait on
// R/B#, then 0x70 and a status read. Every flash pin comes straight from a
// flop, so the pads never see decode glitches.
module nand_page_program #(
  parameter int unsigned WE_LOW_CYC  = 2,
  parameter int unsigned WE_HIGH_CYC = 2,
  parameter int unsigned TWB_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk_i,
  input  logic        button_i,
  input  logic        start_i,
  input  logic [15:0] col_addr_i,
  input  logic [23:0] row_addr_i,
  input  logic [12:0] byte_count_i,
  input  logic [7:0]  din_i,
  input  logic        din_valid_i,
  output logic        din_ready_o,
  input  logic        rb_i,
  input  logic [7:0]  io_in_i,
  output logic        ce_o,
  output logic        cle_o,
  output logic        ale_o,
  output logic        we_o,
  output logic        re_o,
  output logic        wp_o,
  output logic [7:0]  io_out_o,
  output logic        io_oe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        timeout_o
);

  localparam int unsigned BUS_CYC  = WE_LOW_CYC + WE_HIGH_CYC;
  localparam int unsigned CYC_W    = $clog2(BUS_CYC + 1);
  localparam int unsigned WAIT_MAX = (TIMEOUT_CYC > TWB_CYC) ? TIMEOUT_CYC : TWB_CYC;
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

  localparam logic [CYC_W-1:0] CYC_LAST     = CYC_W'(BUS_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_LOW_LAST = CYC_W'(WE_LOW_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_HIGH     = CYC_W'(WE_LOW_CYC);
  localparam logic [CYC_W-1:0] CYC_ONE      = CYC_W'(1);
  localparam logic [CNT_W-1:0] TWB_LAST     = CNT_W'(TWB_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST      = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD1,
    S_ADDR,
    S_DATA,
    S_CMD2,
    S_WAIT_BUSY,
    S_WAIT_READY,
    S_STAT_CMD,
    S_STAT_READ,
    S_FINISH
  } state_e;

  // Sequencer state
  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;          // phase within the current bus cycle
  logic [2:0]       idx_q, idx_d;          // address cycle index
  logic [12:0]      rem_q, rem_d;          // data bytes still to be accepted
  logic             bus_act_q, bus_act_d;  // a data bus cycle is in flight
  logic [7:0]       dat_q, dat_d;
  logic [15:0]      col_q, col_d;
  logic [23:0]      row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;          // tWB / ready timeout counter
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;

  // Registered pin values
  logic       ce_q, ce_d;
  logic       cle_q, cle_d;
  logic       ale_q, ale_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       wp_q, wp_d;
  logic [7:0] io_out_q, io_out_d;
  logic       io_oe_q, io_oe_d;
  logic       din_ready_q, din_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic rb_meta_q, rb_sync_q;
  logic bus_last, handshake, strobe_low;

  // Only status bit0 (pass/fail) matters for a page program.
  logic io_in_unused;
  assign io_in_unused = &{1'b0, io_in_i[7:1]};

  function automatic logic [7:0] addr_byte(input logic [2:0]  idx,
                                           input logic [15:0] col,
                                           input logic [23:0] row);
    case (idx)
      3'd0:    addr_byte = col[7:0];
      3'd1:    addr_byte = col[15:8];
      3'd2:    addr_byte = row[7:0];
      3'd3:    addr_byte = row[15:8];
      default: addr_byte = row[23:16];
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous ready/busy pin.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge button_i) begin
    if (!button_i) begin
      rb_meta_q <= 1'b1;
      rb_sync_q <= 1'b1;
    end else begin
      rb_meta_q <= rb_i;
      rb_sync_q <= rb_meta_q;
    end
  end

  assign bus_last  = (cyc_q == CYC_LAST);
  assign handshake = din_valid_i && din_ready_q;

  // Next-state logic: walks the command sequence one bus phase at a time.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    bus_act_d = bus_act_q;
    dat_d     = dat_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          col_d     = col_addr_i;
          row_d     = row_addr_i;
          rem_d     = byte_count_i;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          cyc_d     = '0;
          idx_d     = '0;
          bus_act_d = 1'b0;
          state_d   = S_CMD1;
        end
      end

      S_CMD1: begin
        if (bus_last) begin
          cyc_d   = '0;
          idx_d   = '0;
          state_d = S_ADDR;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      S_ADDR: begin
        if (bus_last) begin
          cyc_d = '0;
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = (rem_q == '0) ? S_CMD2 : S_DATA;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      S_DATA: begin
        if (bus_act_q) begin
          if (bus_last) begin
            cyc_d     = '0;
            bus_act_d = 1'b0;
            if (rem_q == '0) state_d = S_CMD2;
          end else begin
            cyc_d = cyc_q + CYC_ONE;
          end
        end else if (handshake) begin
          // Byte captured now; its write strobe starts next cycle.
          dat_d     = din_i;
          rem_d     = rem_q - 13'd1;
          bus_act_d = 1'b1;
          cyc_d     = '0;
        end
      end

      S_CMD2: begin
        if (bus_last) begin
          cyc_d   = '0;
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      S_WAIT_BUSY: begin
        // The flash may go busy late or finish before we ever see it low.
        if (!rb_sync_q || (cnt_q == TWB_LAST)) begin
          cnt_d   = '0;
          state_d = S_WAIT_READY;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WAIT_READY: begin
        if (rb_sync_q) begin
          cnt_d   = '0;
          cyc_d   = '0;
          state_d = S_STAT_CMD;
        end else if (cnt_q == TO_LAST) begin
          cnt_d     = '0;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STAT_CMD: begin
        if (bus_last) begin
          cyc_d   = '0;
          state_d = S_STAT_READ;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      S_STAT_READ: begin
        // Sample on the last RE-low cycle, when read data has settled longest.
        if (cyc_q == CYC_LOW_LAST) fail_d = io_in_i[0];
        if (bus_last) begin
          cyc_d   = '0;
          state_d = S_FINISH;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin decode from the next state, so the pins are registered yet track the state exactly.
  always_comb begin
    ce_d        = 1'b1;
    cle_d       = 1'b0;
    ale_d       = 1'b0;
    we_d        = 1'b1;
    re_d        = 1'b1;
    wp_d        = 1'b0;
    io_out_d    = 8'h00;
    io_oe_d     = 1'b0;
    din_ready_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    strobe_low  = (cyc_d < CYC_HIGH);

    if (state_d != S_IDLE) begin
      ce_d   = 1'b0;
      wp_d   = 1'b1;
      busy_d = 1'b1;
    end

    unique case (state_d)
      S_CMD1: begin
        cle_d    = 1'b1;
        io_oe_d  = 1'b1;
        io_out_d = 8'h80;
        we_d     = !strobe_low;
      end
      S_ADDR: begin
        ale_d    = 1'b1;
        io_oe_d  = 1'b1;
        io_out_d = addr_byte(idx_d, col_d, row_d);
        we_d     = !strobe_low;
      end
      S_DATA: begin
        io_oe_d     = 1'b1;
        io_out_d    = dat_d;
        we_d        = bus_act_d ? !strobe_low : 1'b1;
        din_ready_d = !bus_act_d && (rem_d != '0);
      end
      S_CMD2: begin
        cle_d    = 1'b1;
        io_oe_d  = 1'b1;
        io_out_d = 8'h10;
        we_d     = !strobe_low;
      end
      S_STAT_CMD: begin
        cle_d    = 1'b1;
        io_oe_d  = 1'b1;
        io_out_d = 8'h70;
        we_d     = !strobe_low;
      end
      S_STAT_READ: begin
        re_d = !strobe_low;
      end
      S_FINISH: begin
        ce_d   = 1'b1;
        wp_d   = 1'b0;
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counters and pin registers.
  always_ff @(posedge clk_i or negedge button_i) begin
    if (!button_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      bus_act_q   <= 1'b0;
      dat_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      ce_q        <= 1'b1;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      we_q        <= 1'b1;
      re_q        <= 1'b1;
      wp_q        <= 1'b0;
      io_out_q    <= '0;
      io_oe_q     <= 1'b0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      bus_act_q   <= bus_act_d;
      dat_q       <= dat_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      ce_q        <= ce_d;
      cle_q       <= cle_d;
      ale_q       <= ale_d;
      we_q        <= we_d;
      re_q        <= re_d;
      wp_q        <= wp_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ce_o        = ce_q;
  assign cle_o       = cle_q;
  assign ale_o       = ale_q;
  assign we_o        = we_q;
  assign re_o        = re_q;
  assign wp_o        = wp_q;
  assign io_out_o    = io_out_q;
  assign io_oe_o     = io_oe_q;
  assign din_ready_o = din_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;

endmodule

// File: doc/nand_page_program.md
Name: nand_page_program

Overview:
- Command sequencer that performs one ONFI-style NAND page program: 0x80, 5 address cycles, N data bytes, 0x10, R/B wait, 0x70 status read.
- Sits directly upstream of the flash pins.
- Replaces the free-running WE toggling/IO test pattern with properly timed bus cycles driven from a start request and a byte stream.

Parameters:
- WE_LOW_CYC, 2, CLK cycles WE (and RE) held low per bus cycle (≥1).
- WE_HIGH_CYC, 2, CLK cycles WE held high after each low phase (≥1); IO/CLE/ALE held through this phase.
- TWB_CYC, 8, max cycles to wait for synced RB to fall after 0x10.
- TIMEOUT_CYC, 100000, max cycles in WAIT_READY before abort.

Ports:
- CLK  in  1  system clock.
- BUTTON  in  1  asynchronous active-low reset.
- START  in  1  request pulse; honoured only when BUSY=0.
- COL_ADDR  in  16  column address, latched at START.
- ROW_ADDR  in  24  row (page/block) address, latched at START.
- BYTE_COUNT  in  13  bytes to program (0..4096), latched at START.
- DIN  in  8  data byte stream.
- DIN_VALID  in  1  DIN valid.
- DIN_READY  out  1  block accepts DIN this cycle.
- RB  in  1  flash ready/busy, async, low = busy.
- IO_IN  in  8  flash IO read-back.
- CE, CLE, ALE, WE, RE, WP  out  1 each  flash controls (CE, WE, RE, WP active-low).
- IO_OUT  out  8  flash IO drive value.
- IO_OE  out  1  1 = drive IO_OUT onto the pads.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle pulse at sequence end.
- FAIL  out  1  status bit0 = 1 or timeout; holds until next START.
- TIMEOUT  out  1  abort due to RB timeout; holds until next START.

Behaviour:
- Reset (BUTTON=0, async):
  - Outputs: CE=1, CLE=0, ALE=0, WE=1, RE=1, WP=0, IO_OUT=0, IO_OE=0, DIN_READY=0, BUSY=0, DONE=0, FAIL=0, TIMEOUT=0.
  - State: IDLE; all counters 0.
  - Reset mid-sequence aborts with no DONE.
- RB: passed through a 2-flop synchronizer; all RB decisions use the synced value.
- States:
  - IDLE → CMD1 → ADDR → DATA → CMD2 → WAIT_BUSY → WAIT_READY → STAT_CMD → STAT_READ → FINISH → IDLE.
- START in IDLE:
  - Latch COL_ADDR, ROW_ADDR, BYTE_COUNT.
  - Clear FAIL and TIMEOUT.
  - Next cycle: BUSY=1, CE=0, WP=1.
  - START while BUSY=1 is ignored.
- Write bus cycle, used by CMD1/ADDR/DATA/CMD2/STAT_CMD:
  - Cycle 0: IO_OUT, CLE/ALE valid, IO_OE=1, WE=0.
  - WE stays low WE_LOW_CYC cycles, then high WE_HIGH_CYC cycles with IO/CLE/ALE unchanged.
  - Total WE_LOW_CYC+WE_HIGH_CYC cycles per bus cycle. CLE/ALE drop at the end of the final cycle of their state.
- CMD1: CLE=1, byte 0x80.
- ADDR: ALE=1, 5 cycles in order COL[7:0], COL[15:8], ROW[7:0], ROW[15:8], ROW[23:16].
- DATA:
  - CLE=ALE=0. DIN_READY=1 only when no bus cycle is in flight and bytes remain.
  - The DIN_VALID&DIN_READY handshake captures DIN and starts a bus cycle on the next cycle.
  - DIN_VALID low stalls with WE=1 indefinitely.
  - Exactly BYTE_COUNT bytes are accepted; BYTE_COUNT=0 skips DATA (CMD2 follows ADDR directly).
- CMD2: CLE=1, 0x10.
- WAIT_BUSY: IO_OE=0. Leave on synced RB=0, or after TWB_CYC cycles regardless.
- WAIT_READY:
  - Leave on synced RB=1.
  - Counter reaching TIMEOUT_CYC causes: FAIL=1, TIMEOUT=1, skip status and go to FINISH.
- STAT_CMD: CLE=1, 0x70, then IO_OE=0.
- STAT_READ:
  - RE=0 for WE_LOW_CYC cycles; IO_IN sampled on the last RE-low cycle.
  - Then RE=1 for WE_HIGH_CYC cycles.
  - FAIL = sampled bit0.
- FINISH (one cycle):
  - CE=1, WP=0, IO_OE=0, DONE=1.
  - BUSY drops the cycle after DONE.
- DIN_READY is never asserted outside DATA.
- WE and RE are never low simultaneously.

Test Plan:
- Reset in IDLE:
  - Stimulus: BUTTON low then high.
  - Required: CE=1, WE=1, RE=1, WP=0, IO_OE=0, BUSY=0 both during and after.
- Program 4 bytes:
  - Stimulus: COL=0x0123, ROW=0x045678, bytes A5,5A,00,FF; RB falls 3 cycles after 0x10 and rises 50 cycles later; status IO_IN=0x00.
  - Required IO sequence at WE rising edges: 80,23,01,78,56,04,A5,5A,00,FF,10,70 with CLE/ALE correct.
  - Required end state: DONE pulse, FAIL=0.
- BYTE_COUNT=0:
  - Required: 0x10 follows the fifth address byte directly; DIN_READY never 1.
- DIN stall:
  - Stimulus: DIN_VALID low 20 cycles mid-DATA.
  - Required: WE held 1, no bytes lost, order preserved.
- Status fail:
  - Stimulus: IO_IN=0x01 on status read.
  - Required: FAIL=1, TIMEOUT=0, DONE pulse.
- Timeout (TIMEOUT_CYC=100):
  - Stimulus: RB stuck low; START pulsed again while BUSY.
  - Required: second START ignored; FAIL=1, TIMEOUT=1, no 0x70 issued, CE=1 after DONE.
